operand_issue_stage: RTL and testbench
======================================

Name: operand_issue_stage

Overview:
- Sits directly upstream of the 3-read/1-write register file, between instruction decode and execute.
- Holds one decoded instruction and drives the register file read addresses from it.
- Uses a 32-entry pending-write scoreboard to block RAW and WAW hazards, and forwards same-cycle writeback data.
- Issues the instruction and its captured operands to execute over a valid/ready handshake. Also drives the register file write port from the writeback bus.

Parameters:
DATA_W, 32, operand/writeback data width
ADDR_W, 5, register address width; register count = 2**ADDR_W
PAYLOAD_W, 32, opaque decoded-instruction bits carried alongside (opcode, pc, imm)

Ports:
clock  in  1  single clock; all state updates on rising edge
reset  in  1  synchronous, active-low reset (sampled on rising edge of clock)
in_valid  in  1  decode offers instruction
in_ready  out  1  stage can accept
in_rs  in  3*ADDR_W  source addresses rs1,rs2,rs3 (rs1 in LSBs)
in_use  in  3  per-source use mask; an unused source is treated as address 0
in_rd  in  ADDR_W  destination
in_wr  in  1  instruction writes in_rd
in_payload  in  PAYLOAD_W  opaque
rf_raddr1/2/3  out  ADDR_W each  register file read addresses (combinational from hold register)
rf_rdata1/2/3  in  DATA_W each  register file async read data
wb_valid  in  1  writeback strobe from execute/memory
wb_addr  in  ADDR_W  writeback destination
wb_data  in  DATA_W  writeback value
rf_we, rf_waddr, rf_wdata  out  1/ADDR_W/DATA_W  register file write port = wb_valid/wb_addr/wb_data, combinational
out_valid  out  1  issued instruction valid
out_ready  in  1  execute accepts
out_op1/2/3  out  DATA_W each  captured operands
out_rd, out_wr, out_payload  out  ADDR_W/1/PAYLOAD_W  forwarded fields
stall_count  out  32  saturating count of hazard-stall cycles

Behaviour:
- Reset (reset==0 at edge):
  - hold_valid=0, out_valid=0, all pending bits=0, stall_count=0.
  - out_op*/out_rd/out_wr/out_payload=0.
  - Reset overrides any simultaneous wb_valid or handshake.
- Accept: in_valid && in_ready at an edge loads the hold register (fields masked by in_use) and sets hold_valid=1.
- in_ready = !hold_valid || issue. A new instruction is accepted in the same cycle the held one issues.
- Source readiness, per used source s with address a:
  - ready if a==0;
  - or pending[a]==0;
  - or (wb_valid && wb_addr==a).
- Forwarded operand:
  - a==0 -> 0;
  - else if wb_valid && wb_addr==a -> wb_data;
  - else rf_rdata.
- Destination hazard (WAW): stall if hold_wr && hold_rd!=0 && pending[hold_rd] && !(wb_valid && wb_addr==hold_rd).
- issue = hold_valid && all sources ready && no WAW && (!out_valid || out_ready).
- On issue:
  - out_* registered from hold plus forwarded operands; out_valid=1.
  - If hold_wr && hold_rd!=0, set pending[hold_rd].
- If out_valid && out_ready && !issue, out_valid->0. Output holds stable while out_valid && !out_ready.
- Scoreboard update per edge:
  - wb_valid clears pending[wb_addr].
  - Issue set on the same address in the same cycle wins (bit ends 1).
  - Address 0 is never set.
- Latency: accept at edge E0 -> out_valid visible after E1 when hazard-free and downstream ready. Sustained throughput is 1 instruction/cycle.
- stall_count increments each cycle hold_valid && !issue, and saturates at 0xFFFFFFFF.
- wb_valid with a non-pending address: write passes through; the scoreboard bit stays 0.

Decomposition:
- Shared package: ADDR_W, DATA_W, register-count constant, source-index constants (SRC1..SRC3).
- One natural sub-module: issue_scoreboard.
  - Holds the 32-bit pending vector with set/clear ports.
  - Provides a combinational per-address query with same-cycle writeback bypass.

Test Plan:
- Reset: hold reset=0 for 2 cycles with wb_valid=1, wb_addr=5 -> out_valid=0, in_ready=1, stall_count=0, pending all 0.
- Independent stream: issue r3=r1+r2 then r6=r4+r5 back-to-back, rf preloaded r1=10, r2=20, r4=4, r5=5, out_ready=1 -> out_valid on consecutive cycles; operands (10,20) then (4,5); no stall.
- RAW stall: issue writer rd=7, then reader rs1=7. Hold wb off 3 cycles, then wb_valid, wb_addr=7, wb_data=0xDEAD -> reader issues in the wb cycle with out_op1=0xDEAD; stall_count=3.
- WAW plus same-cycle set/clear: writer A rd=9 pending; writer B rd=9 waits; wb for 9 arrives -> B issues that cycle and pending[9] remains 1.
- Backpressure: out_ready=0 for 4 cycles -> out_* stable, in_ready=0 once hold is full; release -> both instructions drain in order.
- Reset mid-operation: pending[7]=1, hold_valid=1, out_valid=1, then reset=0 one cycle -> all cleared; the next reader of r7 issues without stall.

Source files
------------

// File: rtl/operand_issue_stage_pkg.sv
// Shared widths and source-slot indices for the operand issue stage and its scoreboard.
package operand_issue_stage_pkg;

    localparam int unsigned OIS_DATA_W    = 32;
    localparam int unsigned OIS_ADDR_W    = 5;
    localparam int unsigned OIS_PAYLOAD_W = 32;
    localparam int unsigned OIS_NUM_REGS  = 2 ** OIS_ADDR_W;

    localparam int unsigned NUM_SRC = 3;
    localparam int unsigned SRC1    = 0;
    localparam int unsigned SRC2    = 1;
    localparam int unsigned SRC3    = 2;

    // Scoreboard query slot used for the destination (WAW) check.
    localparam int unsigned QRY_RD  = 3;
    localparam int unsigned NUM_QRY = 4;

endpackage

// File: rtl/issue_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on writeback.
// Queries see a same-cycle writeback as already cleared; register 0 is never busy.
module issue_scoreboard
    import operand_issue_stage_pkg::*;
#(
    parameter int unsigned ADDR_W = OIS_ADDR_W,
    parameter int unsigned NUM_Q  = NUM_QRY
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    set_en,
    input  logic [ADDR_W-1:0]       set_addr,
    input  logic                    clr_en,
    input  logic [ADDR_W-1:0]       clr_addr,
    input  logic [NUM_Q*ADDR_W-1:0] q_addr,
    output logic [NUM_Q-1:0]        q_busy
);

    localparam int unsigned NREGS = 2 ** ADDR_W;

    logic [NREGS-1:0] pending_q, pending_d;

    always_comb begin
        pending_d = pending_q;
        if (clr_en) begin
            pending_d[clr_addr] = 1'b0;
        end
        // A set on the address being cleared this cycle wins.
        if (set_en && (set_addr != '0)) begin
            pending_d[set_addr] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    for (genvar i = 0; i < NUM_Q; i++) begin : g_query
        logic [ADDR_W-1:0] a;
        assign a         = q_addr[i*ADDR_W +: ADDR_W];
        assign q_busy[i] = (a != '0) && pending_q[a] && !(clr_en && (clr_addr == a));
    end

endmodule

// File: rtl/operand_issue_stage.sv
// Single-entry operand issue stage: holds one decoded instruction, resolves RAW/WAW hazards
// against a pending-write scoreboard, forwards writeback data and issues over valid/ready.
module operand_issue_stage
    import operand_issue_stage_pkg::*;
#(
    parameter int unsigned DATA_W    = OIS_DATA_W,
    parameter int unsigned ADDR_W    = OIS_ADDR_W,
    parameter int unsigned PAYLOAD_W = OIS_PAYLOAD_W
) (
    input  logic                    clock,
    input  logic                    reset,

    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [3*ADDR_W-1:0]     in_rs,
    input  logic [2:0]              in_use,
    input  logic [ADDR_W-1:0]       in_rd,
    input  logic                    in_wr,
    input  logic [PAYLOAD_W-1:0]    in_payload,

    output logic [ADDR_W-1:0]       rf_raddr1,
    output logic [ADDR_W-1:0]       rf_raddr2,
    output logic [ADDR_W-1:0]       rf_raddr3,
    input  logic [DATA_W-1:0]       rf_rdata1,
    input  logic [DATA_W-1:0]       rf_rdata2,
    input  logic [DATA_W-1:0]       rf_rdata3,

    input  logic                    wb_valid,
    input  logic [ADDR_W-1:0]       wb_addr,
    input  logic [DATA_W-1:0]       wb_data,
    output logic                    rf_we,
    output logic [ADDR_W-1:0]       rf_waddr,
    output logic [DATA_W-1:0]       rf_wdata,

    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_op1,
    output logic [DATA_W-1:0]       out_op2,
    output logic [DATA_W-1:0]       out_op3,
    output logic [ADDR_W-1:0]       out_rd,
    output logic                    out_wr,
    output logic [PAYLOAD_W-1:0]    out_payload,
    output logic [31:0]             stall_count
);

    logic                        hold_valid_q, hold_valid_d;
    logic [NUM_SRC*ADDR_W-1:0]   hold_rs_q, hold_rs_d;
    logic [ADDR_W-1:0]           hold_rd_q, hold_rd_d;
    logic                        hold_wr_q, hold_wr_d;
    logic [PAYLOAD_W-1:0]        hold_payload_q, hold_payload_d;

    logic                        out_valid_q, out_valid_d;
    logic [DATA_W-1:0]           out_op_q [NUM_SRC];
    logic [DATA_W-1:0]           out_op_d [NUM_SRC];
    logic [ADDR_W-1:0]           out_rd_q, out_rd_d;
    logic                        out_wr_q, out_wr_d;
    logic [PAYLOAD_W-1:0]        out_payload_q, out_payload_d;
    logic [31:0]                 stall_q, stall_d;

    logic [DATA_W-1:0]           rdata [NUM_SRC];
    logic [DATA_W-1:0]           fwd   [NUM_SRC];
    logic [NUM_SRC*ADDR_W-1:0]   in_rs_masked;
    logic [NUM_QRY-1:0]          busy;
    logic                        srcs_ready, waw, issue, accept, sb_set;

    assign rdata[SRC1] = rf_rdata1;
    assign rdata[SRC2] = rf_rdata2;
    assign rdata[SRC3] = rf_rdata3;

    assign rf_raddr1 = hold_rs_q[SRC1*ADDR_W +: ADDR_W];
    assign rf_raddr2 = hold_rs_q[SRC2*ADDR_W +: ADDR_W];
    assign rf_raddr3 = hold_rs_q[SRC3*ADDR_W +: ADDR_W];

    assign rf_we    = wb_valid;
    assign rf_waddr = wb_addr;
    assign rf_wdata = wb_data;

    // Unused sources collapse to r0 so they are always ready and read as zero.
    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        logic [ADDR_W-1:0] a;
        assign in_rs_masked[s*ADDR_W +: ADDR_W] = in_use[s] ? in_rs[s*ADDR_W +: ADDR_W] : '0;
        assign a = hold_rs_q[s*ADDR_W +: ADDR_W];

        always_comb begin
            if (a == '0) begin
                fwd[s] = '0;
            end else if (wb_valid && (wb_addr == a)) begin
                fwd[s] = wb_data;
            end else begin
                fwd[s] = rdata[s];
            end
        end
    end

    issue_scoreboard #(
        .ADDR_W (ADDR_W),
        .NUM_Q  (NUM_QRY)
    ) u_scoreboard (
        .clock    (clock),
        .reset    (reset),
        .set_en   (sb_set),
        .set_addr (hold_rd_q),
        .clr_en   (wb_valid),
        .clr_addr (wb_addr),
        .q_addr   ({hold_rd_q, hold_rs_q}),
        .q_busy   (busy)
    );

    assign srcs_ready = ~|busy[NUM_SRC-1:0];
    assign waw        = hold_wr_q && busy[QRY_RD];
    assign issue      = hold_valid_q && srcs_ready && !waw && (!out_valid_q || out_ready);
    assign in_ready   = !hold_valid_q || issue;
    assign accept     = in_valid && in_ready;
    assign sb_set     = issue && hold_wr_q && (hold_rd_q != '0);

    always_comb begin
        hold_valid_d   = hold_valid_q;
        hold_rs_d      = hold_rs_q;
        hold_rd_d      = hold_rd_q;
        hold_wr_d      = hold_wr_q;
        hold_payload_d = hold_payload_q;
        if (accept) begin
            hold_valid_d   = 1'b1;
            hold_rs_d      = in_rs_masked;
            hold_rd_d      = in_rd;
            hold_wr_d      = in_wr;
            hold_payload_d = in_payload;
        end else if (issue) begin
            hold_valid_d = 1'b0;
        end
    end

    always_comb begin
        out_valid_d   = out_valid_q;
        out_op_d      = out_op_q;
        out_rd_d      = out_rd_q;
        out_wr_d      = out_wr_q;
        out_payload_d = out_payload_q;
        if (issue) begin
            out_valid_d   = 1'b1;
            out_op_d      = fwd;
            out_rd_d      = hold_rd_q;
            out_wr_d      = hold_wr_q;
            out_payload_d = hold_payload_q;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (hold_valid_q && !issue && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            hold_valid_q   <= 1'b0;
            hold_rs_q      <= '0;
            hold_rd_q      <= '0;
            hold_wr_q      <= 1'b0;
            hold_payload_q <= '0;
            out_valid_q    <= 1'b0;
            for (int s = 0; s < NUM_SRC; s++) begin
                out_op_q[s] <= '0;
            end
            out_rd_q       <= '0;
            out_wr_q       <= 1'b0;
            out_payload_q  <= '0;
            stall_q        <= '0;
        end else begin
            hold_valid_q   <= hold_valid_d;
            hold_rs_q      <= hold_rs_d;
            hold_rd_q      <= hold_rd_d;
            hold_wr_q      <= hold_wr_d;
            hold_payload_q <= hold_payload_d;
            out_valid_q    <= out_valid_d;
            out_op_q       <= out_op_d;
            out_rd_q       <= out_rd_d;
            out_wr_q       <= out_wr_d;
            out_payload_q  <= out_payload_d;
            stall_q        <= stall_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_op1     = out_op_q[SRC1];
    assign out_op2     = out_op_q[SRC2];
    assign out_op3     = out_op_q[SRC3];
    assign out_rd      = out_rd_q;
    assign out_wr      = out_wr_q;
    assign out_payload = out_payload_q;
    assign stall_count = stall_q;

endmodule

// File: tb/tb_operand_issue_stage.sv
// Randomized bench for operand_issue_stage against a per-cycle behavioural model of the
// hold slot, pending-write set, output register and stall counter.
module tb_operand_issue_stage;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int PW = 32;
    localparam int NCYC = 4000;

    logic          clock = 1'b0;
    logic          reset;
    logic          in_valid, in_ready;
    logic [3*AW-1:0] in_rs;
    logic [2:0]    in_use;
    logic [AW-1:0] in_rd;
    logic          in_wr;
    logic [PW-1:0] in_payload;
    logic [AW-1:0] rf_raddr1, rf_raddr2, rf_raddr3;
    logic [DW-1:0] rf_rdata1, rf_rdata2, rf_rdata3;
    logic          wb_valid;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          out_valid, out_ready;
    logic [DW-1:0] out_op1, out_op2, out_op3;
    logic [AW-1:0] out_rd;
    logic          out_wr;
    logic [PW-1:0] out_payload;
    logic [31:0]   stall_count;

    always #5 clock = ~clock;

    // Register file environment: async read, written from the writeback bus.
    logic [DW-1:0] rf [32];
    assign rf_rdata1 = rf[rf_raddr1];
    assign rf_rdata2 = rf[rf_raddr2];
    assign rf_rdata3 = rf[rf_raddr3];

    operand_issue_stage dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_rs       (in_rs),
        .in_use      (in_use),
        .in_rd       (in_rd),
        .in_wr       (in_wr),
        .in_payload  (in_payload),
        .rf_raddr1   (rf_raddr1),
        .rf_raddr2   (rf_raddr2),
        .rf_raddr3   (rf_raddr3),
        .rf_rdata1   (rf_rdata1),
        .rf_rdata2   (rf_rdata2),
        .rf_rdata3   (rf_rdata3),
        .wb_valid    (wb_valid),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_op1     (out_op1),
        .out_op2     (out_op2),
        .out_op3     (out_op3),
        .out_rd      (out_rd),
        .out_wr      (out_wr),
        .out_payload (out_payload),
        .stall_count (stall_count)
    );

    // Reference model state.
    bit          m_hv;
    bit [AW-1:0] m_rs [3];
    bit [AW-1:0] m_rd;
    bit          m_wr;
    bit [PW-1:0] m_pl;
    bit          m_pend [32];
    bit          m_ov;
    bit [DW-1:0] m_op [3];
    bit [AW-1:0] m_ord;
    bit          m_owr;
    bit [PW-1:0] m_opl;
    longint unsigned m_stall;
    bit          c_issue, c_inrdy;
    bit [DW-1:0] c_fwd [3];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_hv = 0; m_rd = '0; m_wr = 0; m_pl = '0;
        m_ov = 0; m_ord = '0; m_owr = 0; m_opl = '0; m_stall = 0;
        for (int s = 0; s < 3; s++) begin
            m_rs[s] = '0;
            m_op[s] = '0;
        end
        for (int r = 0; r < 32; r++) m_pend[r] = 0;
    endfunction

    // Hazard and forwarding decision for the current inputs, evaluated from the rules directly.
    function automatic void model_comb();
        bit all_rdy = 1;
        bit waw;
        for (int s = 0; s < 3; s++) begin
            bit [AW-1:0] a = m_rs[s];
            bit hit = wb_valid && (wb_addr == a);
            if (!(a == 0 || !m_pend[a] || hit)) all_rdy = 0;
            c_fwd[s] = (a == 0) ? '0 : (hit ? wb_data : rf[a]);
        end
        waw = m_wr && (m_rd != 0) && m_pend[m_rd] && !(wb_valid && wb_addr == m_rd);
        c_issue = m_hv && all_rdy && !waw && (!m_ov || out_ready);
        c_inrdy = !m_hv || c_issue;
    endfunction

    function automatic void model_step();
        if (!reset) begin
            model_reset();
        end else begin
            if (m_hv && !c_issue && m_stall < 64'hFFFF_FFFF) m_stall++;
            if (wb_valid) m_pend[wb_addr] = 0;
            if (c_issue) begin
                m_ov = 1;
                m_op = c_fwd;
                m_ord = m_rd; m_owr = m_wr; m_opl = m_pl;
                if (m_wr && m_rd != 0) m_pend[m_rd] = 1;
            end else if (m_ov && out_ready) begin
                m_ov = 0;
            end
            if (in_valid && c_inrdy) begin
                m_hv = 1;
                for (int s = 0; s < 3; s++) m_rs[s] = in_use[s] ? in_rs[s*AW +: AW] : '0;
                m_rd = in_rd; m_wr = in_wr; m_pl = in_payload;
            end else if (c_issue) begin
                m_hv = 0;
            end
        end
        if (wb_valid) rf[wb_addr] = wb_data;
    endfunction

    task automatic drive_random(input int cyc);
        int unsigned pend_list [$];
        reset      = !(($urandom % 250) == 0);
        in_valid   = ($urandom % 10) < 7;
        for (int s = 0; s < 3; s++) in_rs[s*AW +: AW] = AW'($urandom % 8);
        in_use     = 3'($urandom);
        in_rd      = AW'($urandom % 8);
        in_wr      = 1'($urandom);
        in_payload = $urandom;
        out_ready  = ($urandom % 4) != 0;
        wb_valid   = 1'($urandom);
        wb_data    = $urandom;
        for (int r = 1; r < 32; r++) if (m_pend[r]) pend_list.push_back(r);
        if (pend_list.size() > 0 && ($urandom % 4) != 0)
            wb_addr = AW'(pend_list[$urandom % pend_list.size()]);
        else if (($urandom % 8) == 0)
            wb_addr = AW'($urandom);
        else
            wb_addr = AW'($urandom % 8);
        if (cyc % 500 == 250) out_ready = 0;
    endtask

    initial begin
        for (int r = 0; r < 32; r++) rf[r] = $urandom;
        model_reset();
        reset = 0; in_valid = 0; in_rs = '0; in_use = '0; in_rd = '0; in_wr = 0;
        in_payload = '0; out_ready = 0; wb_valid = 1; wb_addr = 5'd5; wb_data = 32'h1234;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clock);
            if (cyc > 0) model_step();
            check_eq("out_valid",   64'(out_valid),   64'(m_ov));
            check_eq("out_op1",     64'(out_op1),     64'(m_op[0]));
            check_eq("out_op2",     64'(out_op2),     64'(m_op[1]));
            check_eq("out_op3",     64'(out_op3),     64'(m_op[2]));
            check_eq("out_rd",      64'(out_rd),      64'(m_ord));
            check_eq("out_wr",      64'(out_wr),      64'(m_owr));
            check_eq("out_payload", 64'(out_payload), 64'(m_opl));
            check_eq("stall_count", 64'(stall_count), 64'(m_stall));
            if (cyc < 2) begin
                reset = 0; in_valid = 0; out_ready = 0;
                wb_valid = 1; wb_addr = 5'd5; wb_data = 32'h1234;
            end else begin
                drive_random(cyc);
            end
            #1;
            model_comb();
            check_eq("in_ready", 64'(in_ready), 64'(c_inrdy));
            check_eq("rf_we",    64'(rf_we),    64'(wb_valid));
            check_eq("rf_waddr", 64'(rf_waddr), 64'(wb_addr));
            check_eq("rf_wdata", 64'(rf_wdata), 64'(wb_data));
            if (m_hv) begin
                check_eq("rf_raddr1", 64'(rf_raddr1), 64'(m_rs[0]));
                check_eq("rf_raddr2", 64'(rf_raddr2), 64'(m_rs[1]));
                check_eq("rf_raddr3", 64'(rf_raddr3), 64'(m_rs[2]));
            end
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
